// File: rtl/cover_toggle_collector_pkg.sv
// cover_pkg: shared definitions for the toggle cover collector slice.
//   COVER_TOTAL  - largest toggle group a single collector may monitor
//   COVER_IDX_W  - default width of an emitted global cover index
//   cover_idx_t  - cover index at the default width
//   cover_vec_t  - toggle vector at maximum group width (narrower vectors are zero-extended)
//   cover_popcount / cover_lowest - population count and lowest-set-bit index
package cover_pkg;

    localparam int unsigned COVER_TOTAL = 1024;
    localparam int unsigned COVER_IDX_W = 32;
    localparam int unsigned COVER_CNT_W = $clog2(COVER_TOTAL + 1);

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;
    typedef logic [COVER_TOTAL-1:0] cover_vec_t;

    function automatic logic [COVER_CNT_W-1:0] cover_popcount(input cover_vec_t v);
        logic [COVER_CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < COVER_TOTAL; i++) begin
            n = n + COVER_CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [COVER_CNT_W-1:0] cover_lowest(input cover_vec_t v);
        logic [COVER_CNT_W-1:0] idx;
        logic                   found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < COVER_TOTAL; i++) begin
            if (v[i] && !found) begin
                idx   = COVER_CNT_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cover_toggle_collector_fifo.sv
// cover_idx_fifo: synchronous FIFO of cover indices.
//   clock, reset    - clock; synchronous active-low reset (empties FIFO)
//   push_i, push_data_i - write request and data (accepted when not full, or full with a pop)
//   pop_i           - remove head (ignored when empty)
//   head_o          - head entry (don't-care when empty)
//   full_o, empty_o, count_o - occupancy status
module cover_idx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [IDX_W-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [IDX_W-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CNT_W'(DEPTH));
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_o   = mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: sticky toggle-cover bitmap with serialised reporting.
//   clock, reset - clock; synchronous active-low reset
//   clear        - clears hit_map/pending/hit_count (FIFO and drop_cnt kept)
//   valid        - WIDTH toggle-hit strobes sampled every cycle
//   out_valid/out_ready/out_index - stream of global cover indices (COVER_INDEX + bit)
//   hit_map, hit_count, all_hit   - sticky bitmap, its popcount, all-covered flag
//   drop_cnt     - saturating count of cycles losing at least one event (DEDUP=0 only)
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int unsigned WIDTH       = 17,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned IDX_W       = COVER_IDX_W,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DEDUP       = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    output logic [WIDTH-1:0]           hit_map,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic                       all_hit,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       hit_map_q, hit_map_d;
    logic [WIDTH-1:0]       pend_q, pend_d;
    logic [CNT_W-1:0]       hit_count_q, hit_count_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0]       base_map;
    logic [WIDTH-1:0]       base_pend;
    logic [WIDTH-1:0]       new_vec;
    logic [WIDTH-1:0]       grant;
    logic [COVER_CNT_W-1:0] grant_idx;
    logic [IDX_W-1:0]       push_data;
    logic                   push;
    logic                   pop;
    logic                   any_drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FCNT_W-1:0]      fifo_count;

    cover_idx_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (out_index),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        out_valid = ~fifo_empty;
        pop       = out_valid & out_ready;
        push      = (|pend_q) & (~fifo_full | pop);

        // Isolate the lowest pending bit arithmetically; index via package helper.
        grant     = push ? (pend_q & (~pend_q + WIDTH'(1))) : '0;
        grant_idx = cover_lowest(cover_vec_t'(pend_q));
        push_data = IDX_W'(COVER_INDEX) + IDX_W'(grant_idx);

        // clear takes effect before this cycle's valid is merged in.
        base_map  = clear ? '0 : hit_map_q;
        base_pend = clear ? '0 : pend_q;
        new_vec   = (DEDUP != 0) ? (valid & ~base_map) : valid;

        hit_map_d   = base_map | valid;
        pend_d      = (base_pend & ~grant) | new_vec;
        hit_count_d = (clear ? '0 : hit_count_q)
                    + CNT_W'(cover_popcount(cover_vec_t'(valid & ~base_map)));

        any_drop   = (DEDUP == 0) && (|(valid & pend_q & ~grant));
        drop_cnt_d = drop_cnt_q;
        if (any_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        hit_map   = hit_map_q;
        hit_count = hit_count_q;
        all_hit   = &hit_map_q;
        drop_cnt  = drop_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_map_q   <= '0;
            pend_q      <= '0;
            hit_count_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            hit_map_q   <= hit_map_d;
            pend_q      <= pend_d;
            hit_count_q <= hit_count_d;
            drop_cnt_q  <= drop_cnt_d;
            assert (fifo_empty == (fifo_count == '0));
        end
    end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench: two collectors (DEDUP=1 and DEDUP=0) share the same stimulus; a
// per-instance reference model predicts pushes into a scoreboard queue and a
// negedge monitor checks outputs and handshakes against it.
module tb_cover_toggle_collector;

    localparam int unsigned W    = 17;
    localparam int unsigned CI   = 100;
    localparam int unsigned D    = 4;
    localparam int unsigned IW   = 32;
    localparam int unsigned HC_W = $clog2(W + 1);
    localparam logic [W-1:0] ALL = '1;

    logic            clock;
    logic            reset;
    logic            clear;
    logic [W-1:0]    valid;
    logic            out_ready;

    logic            ov [2];
    logic [IW-1:0]   oi [2];
    logic [W-1:0]    hm [2];
    logic [HC_W-1:0] hc [2];
    logic            ah [2];
    logic [15:0]     dc [2];

    cover_toggle_collector #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .IDX_W       (IW),
        .DEPTH       (D),
        .DEDUP       (1)
    ) u_dut_dd (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .valid     (valid),
        .out_valid (ov[0]),
        .out_ready (out_ready),
        .out_index (oi[0]),
        .hit_map   (hm[0]),
        .hit_count (hc[0]),
        .all_hit   (ah[0]),
        .drop_cnt  (dc[0])
    );

    cover_toggle_collector #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .IDX_W       (IW),
        .DEPTH       (D),
        .DEDUP       (0)
    ) u_dut_nd (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .valid     (valid),
        .out_valid (ov[1]),
        .out_ready (out_ready),
        .out_index (oi[1]),
        .hit_map   (hm[1]),
        .hit_count (hc[1]),
        .all_hit   (ah[1]),
        .drop_cnt  (dc[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    bit mhit  [2][W];
    bit mpend [2][W];
    int mcnt  [2];
    int mdrop [2];
    int mq    [2][$];
    int sbq   [2][$];

    task automatic check(input string name, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[dut%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge of instance k (k=0 deduplicates).
    task automatic model_step(input int k);
        bit dd;
        int g;
        bit pop;
        bit push;
        bit dropped;
        dd = (k == 0);
        if (!reset) begin
            for (int i = 0; i < W; i++) begin
                mhit[k][i]  = 0;
                mpend[k][i] = 0;
            end
            mcnt[k]  = 0;
            mdrop[k] = 0;
            mq[k].delete();
            sbq[k].delete();
            return;
        end
        g = -1;
        for (int i = 0; i < W; i++) if (mpend[k][i] && g < 0) g = i;
        pop  = (mq[k].size() > 0) && out_ready;
        push = (g >= 0) && ((mq[k].size() < D) || pop);
        dropped = 0;
        for (int i = 0; i < W; i++)
            if (valid[i] && mpend[k][i] && !(push && i == g)) dropped = 1;
        if (!dd && dropped && mdrop[k] < 65535) mdrop[k]++;
        if (pop) void'(mq[k].pop_front());
        if (push) begin
            mq[k].push_back(CI + g);
            sbq[k].push_back(CI + g);
            mpend[k][g] = 0;
        end
        if (clear) begin
            for (int i = 0; i < W; i++) begin
                mhit[k][i]  = 0;
                mpend[k][i] = 0;
            end
            mcnt[k] = 0;
        end
        for (int i = 0; i < W; i++) begin
            if (valid[i]) begin
                if (!dd || !mhit[k][i]) mpend[k][i] = 1;
                if (!mhit[k][i]) begin
                    mhit[k][i] = 1;
                    mcnt[k]++;
                end
            end
        end
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) model_step(k);
        started = 1;
    end

    // Monitor: compare status every cycle and pop the scoreboard on handshakes.
    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [W-1:0] emap;
                bit eall;
                eall = 1;
                for (int i = 0; i < W; i++) begin
                    emap[i] = mhit[k][i];
                    if (!mhit[k][i]) eall = 0;
                end
                check("out_valid", k, longint'(ov[k]), longint'(mq[k].size() > 0));
                check("hit_map", k, longint'(hm[k]), longint'(emap));
                check("hit_count", k, longint'(hc[k]), longint'(mcnt[k]));
                check("all_hit", k, longint'(ah[k]), longint'(eall));
                check("drop_cnt", k, longint'(dc[k]), longint'(mdrop[k]));
                if (ov[k] === 1'b1 && out_ready) begin
                    if (sbq[k].size() == 0) begin
                        check("unexpected_out", k, longint'(oi[k]), -1);
                    end else begin
                        check("out_index", k, longint'(oi[k]), longint'(sbq[k].pop_front()));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic [W-1:0] v, input bit c);
        valid = v;
        clear = c;
        @(posedge clock);
        #1;
        valid = '0;
        clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        valid     = '0;
        out_ready = 1'b1;
        idle(3);
        reset = 1'b1;

        // single hit, then a repeat of the same point
        drive(W'(1) << 5, 1'b0);
        idle(5);
        drive(W'(1) << 5, 1'b0);
        idle(5);

        // full burst drained with ready high
        drive(ALL, 1'b0);
        idle(25);

        // same burst under back-pressure
        drive('0, 1'b1);
        out_ready = 1'b0;
        drive(ALL, 1'b0);
        idle(10);
        out_ready = 1'b1;
        idle(25);

        // clear together with a new hit
        drive(W'(1) << 3, 1'b1);
        idle(6);

        // fill FIFO, then hold valid[0] for three cycles with FIFO full
        out_ready = 1'b0;
        drive('0, 1'b1);
        drive(W'(5'h1E), 1'b0);
        idle(6);
        valid = W'(1);
        idle(3);
        valid = '0;
        idle(2);
        out_ready = 1'b1;
        idle(12);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            valid     = W'($urandom & $urandom & $urandom);
            clear     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        idle(40);

        // reset while draining a back-pressured burst
        drive('0, 1'b1);
        out_ready = 1'b0;
        drive(ALL, 1'b0);
        idle(3);
        reset = 1'b0;
        idle(1);
        reset     = 1'b1;
        out_ready = 1'b1;
        idle(10);

        for (int k = 0; k < 2; k++) check("leftover_expected", k, sbq[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
